// File: rtl/vproc_pkg.sv
// Shared vector-processor types: read request descriptor, read-stream FSM states
// and the beat-count helper used by register-file read clients.
package vproc_pkg;

    localparam int unsigned VPROC_ID_W = 4;

    typedef struct packed {
        logic [4:0]            vreg;
        logic [1:0]            emul;
        logic [VPROC_ID_W-1:0] id;
    } vreg_rdreq_t;

    typedef enum logic {
        RD_IDLE   = 1'b0,
        RD_STREAM = 1'b1
    } vreg_rd_state_e;

    // Number of read-port beats needed to cover a group of 2**emul registers.
    function automatic int unsigned vreg_rd_beats(input logic [1:0]  emul,
                                                  input int unsigned vreg_w,
                                                  input int unsigned port_w);
        return (vreg_w / port_w) << emul;
    endfunction

endpackage

// File: rtl/vproc_vreg_rdstage.sv
// One-entry valid/ready output register: loads when empty or being drained,
// holds its payload stable while valid and not ready, flush empties it.
module vproc_vreg_rdstage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = 4,
    parameter int unsigned BEAT_W = 5
) (
    input  logic              clk_i,
    input  logic              async_rst_ni,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [ID_W-1:0]   in_id_i,
    input  logic [BEAT_W-1:0] in_beat_i,
    input  logic              in_last_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [ID_W-1:0]   out_id_o,
    output logic [BEAT_W-1:0] out_beat_o,
    output logic              out_last_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              last_q, last_d;
    logic              load;

    assign in_ready_o = ~valid_q | out_ready_i;
    assign load       = in_valid_i & in_ready_o & ~flush_i;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        id_d    = id_q;
        beat_d  = beat_q;
        last_d  = last_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = in_data_i;
            id_d    = in_id_i;
            beat_d  = in_beat_i;
            last_d  = in_last_i;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            id_q    <= '0;
            beat_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            id_q    <= id_d;
            beat_q  <= beat_d;
            last_q  <= last_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_id_o    = id_q;
    assign out_beat_o  = beat_q;
    assign out_last_o  = last_q;

endmodule

// File: rtl/vproc_vreg_rdstream.sv
// Streams a vector register (or aligned group) out of a register-file read port,
// one PORT_W beat per cycle; first beat valid 2 cycles after accept; stalls on !out_ready_i.
module vproc_vreg_rdstream
    import vproc_pkg::*;
#(
    parameter int unsigned VREG_W = 128,
    parameter int unsigned PORT_W = 32,
    parameter int unsigned ID_W   = VPROC_ID_W,
    localparam int unsigned BEATS = VREG_W / PORT_W,
    localparam int unsigned L     = $clog2(BEATS),
    localparam int unsigned AW    = 5 + L,
    localparam int unsigned CW    = L + 3
) (
    input  logic              clk_i,
    input  logic              async_rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [4:0]        req_vreg_i,
    input  logic [1:0]        req_emul_i,
    input  logic [ID_W-1:0]   req_id_i,
    input  logic              flush_i,
    output logic              err_o,
    output logic [AW-1:0]     rd_addr_o,
    input  logic [PORT_W-1:0] rd_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [PORT_W-1:0] out_data_o,
    output logic [ID_W-1:0]   out_id_o,
    output logic [CW-1:0]     out_beat_o,
    output logic              out_last_o,
    output logic              busy_o
);

    vreg_rd_state_e  state_q, state_d;
    logic [AW-1:0]   base_q, base_d;
    logic [CW-1:0]   last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [ID_W-1:0] id_q, id_d;
    logic            err_q, err_d;

    vreg_rdreq_t req;
    logic        misaligned;
    logic        accept;
    logic        stage_valid;
    logic        stage_ready;
    logic        issue;

    assign req = '{vreg: req_vreg_i, emul: req_emul_i, id: VPROC_ID_W'(req_id_i)};

    // A group of 2**emul registers must start on a multiple of 2**emul.
    assign misaligned = |(req.vreg & ((5'd1 << req.emul) - 5'd1));
    assign accept     = req_valid_i & req_ready_o;

    assign stage_valid = (state_q == RD_STREAM) & ~flush_i;
    assign issue       = stage_valid & stage_ready;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        id_d        = id_q;
        err_d       = accept & misaligned;
        req_ready_o = 1'b0;
        rd_addr_o   = '0;
        case (state_q)
            RD_IDLE: begin
                req_ready_o = ~flush_i;
                if (accept && !misaligned) begin
                    base_d  = AW'(req.vreg) << L;
                    // Store the final beat index: the beat total itself can need one bit more than CW.
                    last_d  = CW'(vreg_rd_beats(req.emul, VREG_W, PORT_W) - 1);
                    id_d    = ID_W'(req.id);
                    cnt_d   = '0;
                    state_d = RD_STREAM;
                end
            end
            RD_STREAM: begin
                rd_addr_o = base_q + AW'(cnt_q);
                if (issue) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == last_q) begin
                        cnt_d   = '0;
                        state_d = RD_IDLE;
                    end
                end
            end
            default: state_d = RD_IDLE;
        endcase
        if (flush_i) begin
            state_d = RD_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            state_q <= RD_IDLE;
            base_q  <= '0;
            last_q  <= '0;
            cnt_q   <= '0;
            id_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            err_q   <= err_d;
        end
    end

    vproc_vreg_rdstage #(
        .DATA_W (PORT_W),
        .ID_W   (ID_W),
        .BEAT_W (CW)
    ) u_stage (
        .clk_i        (clk_i),
        .async_rst_ni (async_rst_ni),
        .flush_i      (flush_i),
        .in_valid_i   (stage_valid),
        .in_ready_o   (stage_ready),
        .in_data_i    (rd_data_i),
        .in_id_i      (id_q),
        .in_beat_i    (cnt_q),
        .in_last_i    (cnt_q == last_q),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_data_o   (out_data_o),
        .out_id_o     (out_id_o),
        .out_beat_o   (out_beat_o),
        .out_last_o   (out_last_o)
    );

    assign err_o  = err_q;
    assign busy_o = (state_q != RD_IDLE) | out_valid_o;

endmodule

// File: tb/tb_vproc_vreg_rdstream.sv
// Bench for vproc_vreg_rdstream: directed requests against a register-file model,
// beats checked through an expected-beat queue as the consumer accepts them.
module tb_vproc_vreg_rdstream;

    logic        clk_i = 1'b0;
    logic        async_rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [4:0]  req_vreg_i;
    logic [1:0]  req_emul_i;
    logic [3:0]  req_id_i;
    logic        flush_i;
    logic        err_o;
    logic [6:0]  rd_addr_o;
    logic [31:0] rd_data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_data_o;
    logic [3:0]  out_id_o;
    logic [4:0]  out_beat_o;
    logic        out_last_o;
    logic        busy_o;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  id;
        logic [4:0]  beat;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_e;
    int    n_chk  = 0;
    int    n_pass = 0;

    vproc_vreg_rdstream dut (
        .clk_i        (clk_i),
        .async_rst_ni (async_rst_ni),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_vreg_i   (req_vreg_i),
        .req_emul_i   (req_emul_i),
        .req_id_i     (req_id_i),
        .flush_i      (flush_i),
        .err_o        (err_o),
        .rd_addr_o    (rd_addr_o),
        .rd_data_i    (rd_data_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_data_o   (out_data_o),
        .out_id_o     (out_id_o),
        .out_beat_o   (out_beat_o),
        .out_last_o   (out_last_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Register-file model: every byte of a register beat holds its address.
    always_comb rd_data_i = 32'(rd_addr_o) * 32'h0101_0101;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    endtask

    // Consumer side: each accepted beat is popped and compared.
    always @(negedge clk_i) begin
        if (out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", out_valid_o, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_data", out_data_o, mon_e.data);
                chk("out_id",   out_id_o,   mon_e.id);
                chk("out_beat", out_beat_o, mon_e.beat);
                chk("out_last", out_last_o, mon_e.last);
            end
        end
    end

    // Returns just after the accepting edge.
    task automatic send_req(input logic [4:0] v, input logic [1:0] e, input logic [3:0] id,
                            input bit bad);
        int    k;
        int    n;
        beat_t b;
        req_valid_i = 1'b1;
        req_vreg_i  = v;
        req_emul_i  = e;
        req_id_i    = id;
        k = 0;
        @(negedge clk_i);
        while (!req_ready_o && k < 100) begin
            @(negedge clk_i);
            k++;
        end
        if (!req_ready_o) chk("accept_timeout", req_ready_o, 1'b1);
        if (!bad) begin
            n = 4 << e;
            for (int i = 0; i < n; i++) begin
                b.data = (32'(v) * 4 + 32'(i)) * 32'h0101_0101;
                b.id   = id;
                b.beat = 5'(i);
                b.last = (i == n - 1);
                exp_q.push_back(b);
            end
        end
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy_o) && k < 500) begin
            @(posedge clk_i);
            #1;
            k++;
        end
        chk({tag, "_pending"}, exp_q.size(), 0);
        chk({tag, "_busy"}, busy_o, 1'b0);
    endtask

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        async_rst_ni = 1'b0;
        req_valid_i  = 1'b0;
        req_vreg_i   = '0;
        req_emul_i   = '0;
        req_id_i     = '0;
        flush_i      = 1'b0;
        out_ready_i  = 1'b1;
        #12;
        chk("rst_req_ready", req_ready_o, 1'b1);
        chk("rst_err",       err_o,       1'b0);
        chk("rst_valid",     out_valid_o, 1'b0);
        chk("rst_last",      out_last_o,  1'b0);
        chk("rst_busy",      busy_o,      1'b0);
        chk("rst_addr",      rd_addr_o,   7'd0);
        chk("rst_data",      out_data_o,  32'd0);
        chk("rst_id",        out_id_o,    4'd0);
        chk("rst_beat",      out_beat_o,  5'd0);
        #11 async_rst_ni = 1'b1;
        step();

        // single register, full rate
        send_req(5'd3, 2'd0, 4'h3, 1'b0);
        chk("t1_addr0", rd_addr_o, 7'd12);
        chk("t1_busy", busy_o, 1'b1);
        chk("t1_nvalid", out_valid_o, 1'b0);
        step();
        chk("t1_valid", out_valid_o, 1'b1);
        chk("t1_addr1", rd_addr_o, 7'd13);
        step();
        chk("t1_addr2", rd_addr_o, 7'd14);
        drain("t1");

        // two-register group
        send_req(5'd4, 2'd1, 4'h9, 1'b0);
        chk("t2_addr0", rd_addr_o, 7'd16);
        drain("t2");

        // backpressure while beat 1 is presented
        send_req(5'd3, 2'd0, 4'h5, 1'b0);
        step();
        step();
        out_ready_i = 1'b0;
        chk("t3_beat1", out_data_o, 32'h0D0D_0D0D);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("t3_hold_data", out_data_o, 32'h0D0D_0D0D);
            chk("t3_hold_addr", rd_addr_o, 7'd14);
            chk("t3_hold_valid", out_valid_o, 1'b1);
        end
        out_ready_i = 1'b1;
        drain("t3");

        // misaligned group rejected, aligned one follows
        send_req(5'd5, 2'd1, 4'h1, 1'b1);
        chk("t4_err", err_o, 1'b1);
        chk("t4_ready", req_ready_o, 1'b1);
        chk("t4_nvalid", out_valid_o, 1'b0);
        step();
        chk("t4_err_clr", err_o, 1'b0);
        chk("t4_nbusy", busy_o, 1'b0);
        send_req(5'd6, 2'd1, 4'h2, 1'b0);
        chk("t4_addr0", rd_addr_o, 7'd24);
        chk("t4_err_low", err_o, 1'b0);
        drain("t4");

        // flush as beat 2 issues, with a competing request
        send_req(5'd3, 2'd0, 4'h7, 1'b0);
        step();
        step();
        chk("t5_addr2", rd_addr_o, 7'd14);
        flush_i     = 1'b1;
        req_valid_i = 1'b1;
        req_vreg_i  = 5'd8;
        req_emul_i  = 2'd0;
        req_id_i    = 4'hC;
        step();
        exp_q.delete();
        chk("t5_valid", out_valid_o, 1'b0);
        chk("t5_busy", busy_o, 1'b0);
        chk("t5_nready", req_ready_o, 1'b0);
        step();
        chk("t5_not_accepted", busy_o, 1'b0);
        chk("t5_addr_idle", rd_addr_o, 7'd0);
        flush_i = 1'b0;
        send_req(5'd8, 2'd0, 4'hC, 1'b0);
        chk("t5_addr_new", rd_addr_o, 7'd32);
        drain("t5");

        // asynchronous reset in the middle of a stream
        send_req(5'd4, 2'd1, 4'h6, 1'b0);
        step();
        step();
        #2 async_rst_ni = 1'b0;
        #1;
        chk("t6_valid", out_valid_o, 1'b0);
        chk("t6_busy", busy_o, 1'b0);
        chk("t6_addr", rd_addr_o, 7'd0);
        chk("t6_data", out_data_o, 32'd0);
        chk("t6_ready", req_ready_o, 1'b1);
        exp_q.delete();
        #3 async_rst_ni = 1'b1;
        step();
        send_req(5'd0, 2'd0, 4'h4, 1'b0);
        chk("t6_addr0", rd_addr_o, 7'd0);
        step();
        chk("t6_addr1", rd_addr_o, 7'd1);
        drain("t6");

        // eight-register group under random backpressure
        send_req(5'd8, 2'd3, 4'hA, 1'b0);
        for (int k = 0; k < 2000 && (exp_q.size() != 0 || busy_o); k++) begin
            out_ready_i = 1'($urandom_range(0, 1));
            step();
        end
        out_ready_i = 1'b1;
        drain("t7");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vproc_vreg_rdstream.md
Name: vproc_vreg_rdstream

Overview:
Read-side client of the vector register file's read ports. It accepts a request for one vector register or an aligned register group and drives the file's read address. It captures the combinational read data and streams the register contents out one PORT_W beat per cycle, with valid/ready backpressure. One instance serves one register-file read port in the execution units' operand fetch path.

Parameters:
VREG_W, 128, vector register width in bits; power of two, at least PORT_W.
PORT_W, 32, read port width in bits; power of two, at least 8.
ID_W, 4, width of the opaque request tag carried to the output.
Derived constants: BEATS = VREG_W/PORT_W; L = $clog2(BEATS); addr width AW = 5+L; beat counter width CW = L+3.

Ports:
clk_i  input  1  clock, all state on rising edge
async_rst_ni  input  1  reset, asynchronous, active-low
req_valid_i  input  1  read request valid
req_ready_o  output  1  request accepted when valid & ready
req_vreg_i  input  5  first vector register of the group
req_emul_i  input  2  log2 of group size (0..3 = 1,2,4,8 registers)
req_id_i  input  ID_W  tag returned with every beat
flush_i  input  1  abort current stream
err_o  output  1  one-cycle pulse: misaligned request rejected
rd_addr_o  output  AW  to register file read port, {vreg, beat}
rd_data_i  input  PORT_W  from register file read port, combinational from rd_addr_o
out_valid_o  output  1  output beat valid
out_ready_i  input  1  consumer ready
out_data_o  output  PORT_W  beat data
out_id_o  output  ID_W  tag of the owning request
out_beat_o  output  CW  beat index within the group
out_last_o  output  1  final beat of the group
busy_o  output  1  FSM not IDLE or output stage valid

Behaviour:
- Clock and reset are decided: one clock clk_i; reset async_rst_ni is asynchronous and active-low.
- Reset values: state IDLE; req_ready_o=1; err_o, out_valid_o, out_last_o and busy_o all 0; rd_addr_o, out_data_o, out_id_o and out_beat_o all 0.
- FSM states:
  - IDLE: req_ready_o = !flush_i.
  - STREAM: req_ready_o = 0.
- Accept = req_valid_i & req_ready_o.
  - On accept, alignment check: misaligned when req_vreg_i[emul-1:0] != 0.
  - Misaligned: err_o=1 for the next cycle only; state stays IDLE; no beats.
  - Aligned: latch base = {req_vreg_i, L'b0}, total = BEATS<<emul, id; cnt=0; go to STREAM.
- STREAM:
  - rd_addr_o = base + cnt. The add cannot overflow AW bits because of alignment.
  - issue = (!out_valid_o | out_ready_i).
  - On issue, the output register loads out_data_o=rd_data_i, out_beat_o=cnt, out_id_o=id, out_last_o=(cnt==total-1), and out_valid_o=1. cnt then increments.
  - When the last beat issues, go to IDLE.
  - Without issue, rd_addr_o and cnt hold.
- Output stage:
  - out_valid_o clears on out_ready_i when there is no new issue.
  - Data, id, beat and last stay stable while valid & !ready.
- Latency:
  - rd_addr_o presents the first address the cycle after accept.
  - First out_valid_o appears 2 cycles after accept.
  - Steady state is 1 beat/cycle with out_ready_i=1.
  - Back-to-back requests have a 1-cycle address bubble for the IDLE accept. The output may still hold the previous last beat during that cycle.
- rd_addr_o in IDLE = 0 (don't-care for the file; it is fixed for determinism).
- flush_i:
  - Next cycle: state IDLE, out_valid_o=0, cnt=0.
  - flush_i has priority over issue and over accept in the same cycle.
  - err_o is still cleared normally.
- Hazards: a write to the file in the same cycle returns the old data, because reads are before the write edge. The block does no hazard tracking; the issuing unit owns ordering.
- Reset mid-stream: immediate return to reset values; the in-flight stream is lost.

Decomposition:
- Shared package vproc_pkg gains the request struct vreg_rdreq_t {vreg[4:0], emul[1:0], id}.
- vproc_pkg also gains a function vreg_rd_beats(emul, VREG_W, PORT_W).
- The FSM and counter are a single module.
- The output register is a natural sub-module, vproc_vreg_rdstage: a one-entry valid/ready register with hold on backpressure.

Test Plan:
All cases use VREG_W=128, PORT_W=32 (BEATS=4, AW=7), with the bench file model returning data = addr*0x01010101.
1. Accept v3, emul=0, ready=1 -> rd_addr_o 12,13,14,15 on consecutive cycles; out_data 0x0C0C0C0C..0x0F0F0F0F; out_beat 0..3; last only on beat 3; busy_o falls after the final beat.
2. Accept v4, emul=1 -> 8 beats, rd_addr_o 16..23, out_last_o on out_beat_o=7, out_id_o constant equal to req_id_i.
3. v3, emul=0, out_ready_i low for 2 cycles while beat 1 is valid -> out_data_o held at 0x0D0D0D0D; rd_addr_o held at 14; no beat lost or duplicated; all 4 beats delivered.
4. v5, emul=1 -> err_o high exactly 1 cycle; no out_valid_o; req_ready_o stays 1; a following v6, emul=1 streams addrs 24..31.
5. flush_i asserted on the cycle beat 2 issues, together with a new req_valid_i -> next cycle out_valid_o=0 and state IDLE; the new request is not accepted until flush_i drops.
6. async_rst_ni pulsed low mid-stream (between clock edges) -> outputs go to reset values immediately; after release, a new v0 request streams addrs 0..3 correctly.
